// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller: FSM states,
// cause width and the default vector table placement.
package int_pkg;

   localparam int unsigned CAUSE_W          = 3;
   localparam logic [31:0] DEF_HANDLER_BASE = 32'h0000_1000;
   localparam int unsigned DEF_VEC_STRIDE   = 4;

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      HANDLER,
      RETURN,
      RESUME
   } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the unmasked request vector.
module int_prio_enc
   import int_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 4
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [CAUSE_W-1:0] cause_o
);

   always_comb begin
      logic               found;
      logic [CAUSE_W-1:0] idx;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (req_i[i] && !found) begin
            found = 1'b1;
            idx   = CAUSE_W'(i);
         end
      end
      valid_o = found;
      cause_o = idx;
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches request edges, drives the INT_detected /
// INT_restore handshake to the pipeline and redirects fetch to/from handlers.
module int_ctrl
   import int_pkg::*;
#(
   parameter int unsigned NUM_IRQ      = 4,
   parameter logic [31:0] HANDLER_BASE = DEF_HANDLER_BASE,
   parameter int unsigned VEC_STRIDE   = DEF_VEC_STRIDE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               stall,
   input  logic [31:0]        MEM_PC,
   input  logic               WB_eret,
   output logic               INT_detected,
   output logic               INT_restore,
   output logic               pc_redirect,
   output logic [31:0]        redirect_pc,
   output logic [CAUSE_W-1:0] int_cause,
   output logic [31:0]        epc,
   output logic               in_handler,
   output logic [NUM_IRQ-1:0] pending
);

   state_e               state_q;
   logic [NUM_IRQ-1:0]   pending_q, pending_d, irq_prev_q;
   logic [31:0]          epc_q, redirect_pc_q;
   logic [CAUSE_W-1:0]   cause_q;
   logic                 detect_q, restore_q, redirect_q, in_handler_q;

   logic [NUM_IRQ-1:0]   req, rise, clr;
   logic                 enc_valid, take;
   logic [CAUSE_W-1:0]   enc_cause;
   logic [31:0]          vector;

   assign req = pending_q & irq_mask;

   int_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio_enc (
      .req_i   (req),
      .valid_o (enc_valid),
      .cause_o (enc_cause)
   );

   // Detection commits on the edge that enters ENTER, so epc, int_cause and
   // the pending clear are already visible while INT_detected is high.
   assign take      = (state_q == IDLE) && enc_valid && !stall;
   assign clr       = take ? (NUM_IRQ'(1) << enc_cause) : '0;
   assign rise      = irq & ~irq_prev_q;
   assign pending_d = (pending_q & ~clr) | rise;
   assign vector    = HANDLER_BASE + 32'(enc_cause) * 32'(VEC_STRIDE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pending_q     <= '0;
         irq_prev_q    <= '0;
         epc_q         <= '0;
         cause_q       <= '0;
         detect_q      <= 1'b0;
         restore_q     <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         in_handler_q  <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         irq_prev_q    <= irq;
         detect_q      <= 1'b0;
         restore_q     <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (take) begin
                  state_q       <= ENTER;
                  detect_q      <= 1'b1;
                  redirect_q    <= 1'b1;
                  redirect_pc_q <= vector;
                  epc_q         <= MEM_PC;
                  cause_q       <= enc_cause;
                  in_handler_q  <= 1'b1;
               end
            end
            ENTER: state_q <= HANDLER;
            HANDLER: begin
               if (WB_eret && !stall) begin
                  state_q       <= RETURN;
                  restore_q     <= 1'b1;
                  redirect_q    <= 1'b1;
                  redirect_pc_q <= epc_q;
               end
            end
            RETURN: begin
               state_q      <= RESUME;
               in_handler_q <= 1'b0;
            end
            RESUME:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign INT_detected = detect_q;
   assign INT_restore  = restore_q;
   assign pc_redirect  = redirect_q;
   assign redirect_pc  = redirect_pc_q;
   assign int_cause    = cause_q;
   assign epc          = epc_q;
   assign in_handler   = in_handler_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios followed by randomized request
// bursts checked against a transaction-level pending/priority model.
module tb_int_ctrl;

   localparam logic [31:0] HBASE  = 32'h0000_1000;
   localparam int unsigned STRIDE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq, irq_mask, pending;
   logic        stall, WB_eret;
   logic [31:0] MEM_PC, redirect_pc, epc;
   logic        INT_detected, INT_restore, pc_redirect, in_handler;
   logic [2:0]  int_cause;

   int checks   = 0;
   int failures = 0;

   int_ctrl #(
      .NUM_IRQ      (4),
      .HANDLER_BASE (HBASE),
      .VEC_STRIDE   (STRIDE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
      .irq_mask     (irq_mask),
      .stall        (stall),
      .MEM_PC       (MEM_PC),
      .WB_eret      (WB_eret),
      .INT_detected (INT_detected),
      .INT_restore  (INT_restore),
      .pc_redirect  (pc_redirect),
      .redirect_pc  (redirect_pc),
      .int_cause    (int_cause),
      .epc          (epc),
      .in_handler   (in_handler),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("pulse_excl", {31'b0, INT_detected & INT_restore}, 32'h0);
      chk("redirect_pulse", {31'b0, pc_redirect}, {31'b0, INT_detected | INT_restore});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_det"},   {31'b0, INT_detected}, 0);
      chk({tag, "_rst"},   {31'b0, INT_restore}, 0);
      chk({tag, "_redir"}, {31'b0, pc_redirect}, 0);
      chk({tag, "_rpc"},   redirect_pc, 0);
      chk({tag, "_cause"}, {29'b0, int_cause}, 0);
      chk({tag, "_epc"},   epc, 0);
      chk({tag, "_inh"},   {31'b0, in_handler}, 0);
      chk({tag, "_pend"},  {28'b0, pending}, 0);
   endtask

   task automatic wait_detect(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (INT_detected === 1'b1) seen = 1'b1;
         else step();
      end
      chk({tag, "_seen"}, {31'b0, INT_detected}, 1);
   endtask

   // Called in the detect cycle; walks the handler through eret and RESUME.
   task automatic do_return(input string tag, input logic [31:0] exp_epc);
      step();
      chk({tag, "_hdl_det"}, {31'b0, INT_detected}, 0);
      chk({tag, "_hdl_inh"}, {31'b0, in_handler}, 1);
      WB_eret = 1'b1;
      step();
      WB_eret = 1'b0;
      chk({tag, "_restore"}, {31'b0, INT_restore}, 1);
      chk({tag, "_ret_rpc"}, redirect_pc, exp_epc);
      chk({tag, "_ret_inh"}, {31'b0, in_handler}, 1);
      step();
      chk({tag, "_resume_inh"}, {31'b0, in_handler}, 0);
      chk({tag, "_resume_det"}, {31'b0, INT_detected}, 0);
      step();
   endtask

   logic [3:0] pend_m;

   initial begin
      reset = 1'b1; irq = '0; irq_mask = '1; stall = 1'b0; WB_eret = 1'b0; MEM_PC = '0;
      step();
      step();
      reset = 1'b0;
      chk_all_zero("reset");

      // Single request on line 2
      irq = 4'b0100; MEM_PC = 32'h40;
      step();
      chk("t1_det_early", {31'b0, INT_detected}, 0);
      chk("t1_pend", {28'b0, pending}, 32'h4);
      step();
      chk("t1_det", {31'b0, INT_detected}, 1);
      chk("t1_rpc", redirect_pc, 32'h1008);
      chk("t1_epc", epc, 32'h40);
      chk("t1_cause", {29'b0, int_cause}, 2);
      chk("t1_pend_clr", {28'b0, pending}, 0);
      chk("t1_inh", {31'b0, in_handler}, 1);
      do_return("t1", 32'h40);
      for (int i = 0; i < 3; i++) begin
         chk("t1_held_det", {31'b0, INT_detected}, 0);
         chk("t1_held_pend", {28'b0, pending}, 0);
         step();
      end
      irq = '0;
      step();

      // Simultaneous lines 1 and 3
      irq = 4'b1010; MEM_PC = 32'h80;
      step();
      chk("t3_pend", {28'b0, pending}, 32'hA);
      step();
      chk("t3_det1", {31'b0, INT_detected}, 1);
      chk("t3_cause1", {29'b0, int_cause}, 1);
      chk("t3_rpc1", redirect_pc, 32'h1004);
      chk("t3_pend1", {28'b0, pending}, 32'h8);
      do_return("t3a", 32'h80);
      irq = '0;
      step();
      chk("t3_det3", {31'b0, INT_detected}, 1);
      chk("t3_cause3", {29'b0, int_cause}, 3);
      chk("t3_rpc3", redirect_pc, 32'h100C);
      do_return("t3b", 32'h80);

      // Masked line 0 stays pending until unmasked
      irq_mask = 4'b1110; irq = 4'b0001; MEM_PC = 32'hC0;
      step();
      irq = '0;
      step();
      step();
      chk("t4_masked_det", {31'b0, INT_detected}, 0);
      chk("t4_masked_pend", {28'b0, pending}, 32'h1);
      irq_mask = 4'b1111;
      step();
      chk("t4_det", {31'b0, INT_detected}, 1);
      chk("t4_cause", {29'b0, int_cause}, 0);
      chk("t4_rpc", redirect_pc, 32'h1000);
      do_return("t4", 32'hC0);

      // Stall defers detection
      stall = 1'b1; irq = 4'b0010; MEM_PC = 32'h100;
      step();
      irq = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_stall_det", {31'b0, INT_detected}, 0);
      end
      chk("t5_stall_pend", {28'b0, pending}, 32'h2);
      stall = 1'b0;
      step();
      chk("t5_det", {31'b0, INT_detected}, 1);
      chk("t5_cause", {29'b0, int_cause}, 1);
      do_return("t5", 32'h100);

      // Reset mid-handler
      irq = 4'b1000; MEM_PC = 32'h200;
      step();
      step();
      chk("t6_det", {31'b0, INT_detected}, 1);
      step();
      chk("t6_inh", {31'b0, in_handler}, 1);
      reset = 1'b1; irq = '0;
      step();
      reset = 1'b0;
      chk_all_zero("t6_reset");
      WB_eret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_eret_rst", {31'b0, INT_restore}, 0);
         chk("t6_eret_inh", {31'b0, in_handler}, 0);
      end
      WB_eret = 1'b0;

      // Randomized bursts against the pending/priority model
      pend_m = '0;
      irq_mask = '0;
      step();
      for (int it = 0; it < 40; it++) begin
         logic [3:0]  r, m, req, lowbit;
         logic [31:0] pc;
         int          c;
         r  = 4'($urandom);
         m  = 4'($urandom);
         pc = $urandom & 32'hFFFF_FFFC;
         irq = r; MEM_PC = pc;
         step();
         irq = '0;
         pend_m = pend_m | r;
         chk("rnd_pend_acc", {28'b0, pending}, {28'b0, pend_m});
         req = pend_m & m;
         irq_mask = m;
         if ($urandom_range(0, 1) == 1) begin
            stall = 1'b1;
            for (int k = 0; k < 3; k++) begin
               step();
               chk("rnd_stall_det", {31'b0, INT_detected}, 0);
            end
            stall = 1'b0;
         end
         step();
         if (req != 0) begin
            wait_detect("rnd");
            lowbit = req & (~req + 4'd1);
            c = $clog2(lowbit);
            chk("rnd_cause", {29'b0, int_cause}, 32'(c));
            chk("rnd_rpc", redirect_pc, HBASE + 32'(c) * STRIDE);
            chk("rnd_epc", epc, pc);
            pend_m = pend_m & ~lowbit;
            chk("rnd_pend_clr", {28'b0, pending}, {28'b0, pend_m});
            irq_mask = '0;
            do_return("rnd", pc);
         end else begin
            for (int k = 0; k < 3; k++) begin
               chk("rnd_nodet", {31'b0, INT_detected}, 0);
               step();
            end
            chk("rnd_pend_keep", {28'b0, pending}, {28'b0, pend_m});
            irq_mask = '0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
